// File: rtl/nios2_oci_trace_capture.sv
// Nios II OCI debug-trace capture: first-word-fall-through FIFO of {dct_count, dct_buffer}
// frames, saturating statistics and an end-of-test run/ending/drain/done sequencer.
module nios2_oci_trace_capture #(
   parameter int DCT_W  = 30,
   parameter int CNT_W  = 4,
   parameter int DEPTH  = 16,
   parameter int STAT_W = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int DW    = CNT_W + DCT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dct_valid,
   input  logic [DCT_W-1:0]  dct_buffer,
   input  logic [CNT_W-1:0]  dct_count,
   input  logic              test_ending,
   input  logic              test_has_ended,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [DW-1:0]     rd_data,
   output logic [AW:0]       fifo_level,
   output logic [STAT_W-1:0] frame_count,
   output logic [STAT_W-1:0] drop_count,
   output logic              overflow,
   output logic [1:0]        state,
   output logic              done
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_ENDING = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

   state_t          cur_state;
   state_t          next_state;
   logic [DW-1:0]   mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            capture;
   logic            offered;
   logic            pop;
   logic            full;
   logic            wr;
   logic            drop;

   assign capture  = (cur_state == ST_RUN) || (cur_state == ST_ENDING);
   assign offered  = dct_valid && (dct_count != {CNT_W{1'b0}}) && capture;
   assign full     = (fifo_level == FULL_LEVEL);
   assign rd_valid = (fifo_level != {(AW + 1){1'b0}});
   assign pop      = rd_valid && rd_ready;
   // A pop at full frees the slot the concurrent write lands in.
   assign wr       = offered && (!full || pop);
   assign drop     = offered && full && !pop;
   assign rd_data  = rd_valid ? mem[rd_ptr] : {DW{1'b0}};
   assign state    = cur_state;

   // Frame storage; contents past the read pointer are never observed, so no reset.
   always_ff @(posedge clk) begin
      if (wr) begin
         mem[wr_ptr] <= {dct_count, dct_buffer};
      end
   end

   // Pointers, occupancy and saturating statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= {AW{1'b0}};
         rd_ptr      <= {AW{1'b0}};
         fifo_level  <= {(AW + 1){1'b0}};
         frame_count <= {STAT_W{1'b0}};
         drop_count  <= {STAT_W{1'b0}};
         overflow    <= 1'b0;
      end else begin
         if (wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr, pop})
            2'b10:   fifo_level <= fifo_level + (AW + 1)'(1);
            2'b01:   fifo_level <= fifo_level - (AW + 1)'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (wr && (frame_count != {STAT_W{1'b1}})) begin
            frame_count <= frame_count + STAT_W'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != {STAT_W{1'b1}}) begin
               drop_count <= drop_count + STAT_W'(1);
            end
         end
      end
   end

   // End-of-test sequencer state register; done tracks the state on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state <= ST_RUN;
         done      <= 1'b0;
      end else begin
         cur_state <= next_state;
         done      <= (next_state == ST_DONE);
      end
   end

   // Next-state logic; test_has_ended outranks test_ending.
   always_comb begin
      next_state = cur_state;
      case (cur_state)
         ST_RUN: begin
            if (test_has_ended) begin
               next_state = ST_DRAIN;
            end else if (test_ending) begin
               next_state = ST_ENDING;
            end else begin
               next_state = ST_RUN;
            end
         end
         ST_ENDING: begin
            if (test_has_ended) begin
               next_state = ST_DRAIN;
            end else begin
               next_state = ST_ENDING;
            end
         end
         ST_DRAIN: begin
            if ((fifo_level == {(AW + 1){1'b0}}) ||
                ((fifo_level == (AW + 1)'(1)) && pop)) begin
               next_state = ST_DONE;
            end else begin
               next_state = ST_DRAIN;
            end
         end
         ST_DONE: next_state = ST_DONE;
         default: next_state = ST_RUN;
      endcase
   end

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// Scoreboard bench for nios2_oci_trace_capture: a predictor queues expected frames,
// a monitor compares the FIFO head and statistics every cycle.
module tb_nios2_oci_trace_capture;

   localparam int DCT_W  = 30;
   localparam int CNT_W  = 4;
   localparam int DEPTH  = 16;
   localparam int STAT_W = 16;
   localparam int AW     = 4;
   localparam int DW     = CNT_W + DCT_W;
   localparam int SMAX   = 65535;

   logic              clk = 1'b0;
   logic              reset;
   logic              dct_valid;
   logic [DCT_W-1:0]  dct_buffer;
   logic [CNT_W-1:0]  dct_count;
   logic              test_ending;
   logic              test_has_ended;
   logic              rd_ready;
   logic              rd_valid;
   logic [DW-1:0]     rd_data;
   logic [AW:0]       fifo_level;
   logic [STAT_W-1:0] frame_count;
   logic [STAT_W-1:0] drop_count;
   logic              overflow;
   logic [1:0]        state;
   logic              done;

   always #5 clk = ~clk;

   nios2_oci_trace_capture #(
      .DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .STAT_W(STAT_W)
   ) dut (
      .clk(clk), .reset(reset), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
      .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
      .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .fifo_level(fifo_level),
      .frame_count(frame_count), .drop_count(drop_count), .overflow(overflow),
      .state(state), .done(done)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: occupancy, statistics and phase after the most recent edge.
   logic [DW-1:0] exp_q[$];
   int  m_level  = 0;
   int  m_frames = 0;
   int  m_drops  = 0;
   bit  m_ovf    = 1'b0;
   int  m_state  = 0;
   bit  m_done   = 1'b0;
   bit  model_ok = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Predictor: applies the edge's effect using only the bench-driven inputs.
   always @(posedge clk) begin
      int  pop;
      int  push;
      bit  offered;
      if (reset) begin
         exp_q.delete();
         m_level = 0; m_frames = 0; m_drops = 0; m_ovf = 1'b0;
         m_state = 0; m_done = 1'b0; model_ok = 1'b1;
      end else if (model_ok) begin
         offered = dct_valid && (dct_count != 4'd0) && (m_state < 2);
         pop  = (m_level > 0 && rd_ready) ? 1 : 0;
         push = 0;
         if (offered) begin
            if (m_level < DEPTH || pop == 1) begin
               push = 1;
               exp_q.push_back({dct_count, dct_buffer});
               if (m_frames < SMAX) m_frames++;
            end else begin
               if (m_drops < SMAX) m_drops++;
               m_ovf = 1'b1;
            end
         end
         m_level = m_level + push - pop;
         case (m_state)
            0: if (test_has_ended) m_state = 2; else if (test_ending) m_state = 1;
            1: if (test_has_ended) m_state = 2;
            2: if (m_level == 0) m_state = 3;
            default: m_state = m_state;
         endcase
         m_done = (m_state == 3);
      end
   end

   // Monitor: mid-cycle comparison of outputs against the model, pops on handshake.
   always @(negedge clk) begin
      if (model_ok) begin
         chk("rd_valid", 64'(rd_valid), 64'(m_level != 0));
         if (rd_valid) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL rd_data actual=%0h required=no-entry at %0t", rd_data, $time);
            end else begin
               chk("rd_data", 64'(rd_data), 64'(exp_q[0]));
               if (rd_ready) void'(exp_q.pop_front());
            end
         end else begin
            chk("rd_data_empty", 64'(rd_data), 64'd0);
         end
         chk("fifo_level", 64'(fifo_level), 64'(m_level));
         chk("frame_count", 64'(frame_count), 64'(m_frames));
         chk("drop_count", 64'(drop_count), 64'(m_drops));
         chk("overflow", 64'(overflow), 64'(m_ovf));
         chk("state", 64'(state), 64'(m_state));
         chk("done", 64'(done), 64'(m_done));
      end
   end

   task automatic drive(input bit v, input logic [3:0] c, input logic [29:0] d,
                        input bit rdy, input bit te, input bit th);
      dct_valid = v; dct_count = c; dct_buffer = d;
      rd_ready = rdy; test_ending = te; test_has_ended = th;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 4'd0, 30'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic rnd_frame(input bit rdy);
      drive(1'b1, 4'($urandom_range(15, 1)), 30'($urandom), rdy, 1'b0, 1'b0);
   endtask

   task automatic finish_test();
      for (int i = 0; i < 40 && !m_done; i++) drive(1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b1);
      chk("done_reached", 64'(done), 64'd1);
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 4'd0, 30'd0, 1'b0, 1'b0, 1'b0);
      do_reset();

      // T1: three frames, no reads.
      drive(1'b1, 4'hF, 30'h3FFFFFFF, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 4'hF, 30'h00000001, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 4'hF, 30'h2AAAAAAA, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 30'd0, 1'b0, 1'b0, 1'b0);
      chk("t1_head", 64'(rd_data), 64'({4'hF, 30'h3FFFFFFF}));
      chk("t1_level", 64'(fifo_level), 64'd3);

      // T2: overflow, then a write at full together with a pop.
      do_reset();
      for (int i = 0; i < 20; i++) rnd_frame(1'b0);
      chk("t2_drops", 64'(drop_count), 64'd4);
      rnd_frame(1'b1);
      chk("t2_level_full", 64'(fifo_level), 64'd16);

      // T3: zero-count frames ignored; write+pop streaming across pointer wrap.
      for (int i = 0; i < 3; i++) drive(1'b1, 4'd0, 30'($urandom), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) rnd_frame(1'b1);
      for (int i = 0; i < 20; i++) drive(1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b0);

      // T4: ending keeps capturing, has_ended stops it, drain to done.
      do_reset();
      for (int i = 0; i < 5; i++) rnd_frame(1'b0);
      drive(1'b1, 4'h3, 30'h12345, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 4'd0, 30'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) rnd_frame(1'b0);
      chk("t4_level", 64'(fifo_level), 64'd6);
      for (int i = 0; i < 10; i++) drive(1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b0);
      chk("t4_done", 64'(done), 64'd1);

      // T5: both end signals at once on an empty FIFO.
      do_reset();
      drive(1'b0, 4'd0, 30'd0, 1'b0, 1'b1, 1'b1);
      chk("t5_drain", 64'(state), 64'd2);
      drive(1'b0, 4'd0, 30'd0, 1'b0, 1'b0, 1'b0);
      chk("t5_done", 64'(done), 64'd1);

      // T6: reset with seven entries and overflow set.
      do_reset();
      for (int i = 0; i < 20; i++) rnd_frame(1'b0);
      for (int i = 0; i < 9; i++) drive(1'b0, 4'd0, 30'd0, 1'b1, 1'b0, 1'b0);
      chk("t6_pre_level", 64'(fifo_level), 64'd7);
      do_reset();
      chk("t6_level", 64'(fifo_level), 64'd0);
      chk("t6_overflow", 64'(overflow), 64'd0);

      // Randomized rounds with occasional end-of-test requests.
      for (int r = 0; r < 5; r++) begin
         do_reset();
         for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(9, 0) < 7), 4'($urandom_range(15, 0)), 30'($urandom),
                  ($urandom_range(1, 0) == 1), ($urandom_range(99, 0) == 0),
                  (i > 200 && $urandom_range(199, 0) == 0));
         end
         finish_test();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
